// File: rtl/pulse_period_checker_pkg.sv
// Shared types and defaults for the strobe period checker and the divider
// blocks that feed it.
package pulse_period_checker_pkg;

    // One-hot checker states
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        MEASURE = 3'b010,
        LOCKED  = 3'b100
    } pulse_chk_state_t;

    // Default strobe period, lock threshold and counter width
    localparam int unsigned DEF_DIV      = 3;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/pulse_period_checker.sv
// Monitors a single-cycle strobe and checks that it repeats every DIV clocks.
// Reports each measured period, declares lock after LOCK_CNT consecutive
// good periods and pulses err on every short or overdue period.
module pulse_period_checker
    import pulse_period_checker_pkg::*;
#(
    parameter int unsigned DIV      = DEF_DIV,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse_in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_CNT);
    localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

    pulse_chk_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [MC_W-1:0]  match_cnt, match_n;
    logic [CNT_W-1:0] period_n;
    logic             pv_n;
    logic             err_n;

    // Registered state, counters and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            match_cnt    <= match_n;
            period       <= period_n;
            period_valid <= pv_n;
            err          <= err_n;
        end
    end

    // Next-state, period measurement and deviation detection
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        match_n  = match_cnt;
        period_n = period;
        pv_n     = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_n = MEASURE;
                    cnt_n   = CNT_ONE;
                    match_n = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (pulse_in) begin
                    period_n = cnt;
                    pv_n     = 1'b1;
                    cnt_n    = CNT_ONE;
                    if (cnt == DIV_C) begin
                        // match_cnt freezes once locked
                        if (state == MEASURE) begin
                            match_n = match_cnt + MC_ONE;
                            if (match_n == LOCK_C) begin
                                state_n = LOCKED;
                            end
                        end
                    end else begin
                        // Short period: this strobe becomes the new start
                        err_n   = 1'b1;
                        match_n = '0;
                        state_n = MEASURE;
                    end
                end else if (cnt == DIV_C) begin
                    // Overdue: give up and wait for the next strobe
                    err_n   = 1'b1;
                    match_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                match_n = '0;
            end
        endcase
    end

    // Lock indicator decoded from the state register
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_pulse_period_checker.sv
// Self-checking bench for pulse_period_checker: DIV=3/LOCK_CNT=4 instance for
// lock, short, omitted, reset and continuous cases; DIV=1/LOCK_CNT=2 instance
// for the degenerate single-cycle period.
module tb_pulse_period_checker;
    import pulse_period_checker_pkg::*;

    typedef struct packed {
        logic                 locked;
        logic                 err;
        logic [DEF_CNT_W-1:0] period;
        logic                 pv;
    } obs_t;

    logic clk;
    logic reset_n, reset1_n;
    logic pulse0, pulse1;
    logic locked0, err0, pv0;
    logic locked1, err1, pv1;
    logic [DEF_CNT_W-1:0] period0, period1;

    obs_t obs0, obs1;
    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    pulse_period_checker #(.DIV(3), .LOCK_CNT(4), .CNT_W(DEF_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse0),
        .locked(locked0), .err(err0), .period(period0), .period_valid(pv0)
    );

    pulse_period_checker #(.DIV(1), .LOCK_CNT(2), .CNT_W(DEF_CNT_W)) dut1 (
        .clk(clk), .reset_n(reset1_n), .pulse_in(pulse1),
        .locked(locked1), .err(err1), .period(period1), .period_valid(pv1)
    );

    assign obs0 = {locked0, err0, period0, pv0};
    assign obs1 = {locked1, err1, period1, pv1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t mk(input logic l, input logic e,
                                input logic [DEF_CNT_W-1:0] p, input logic v);
        return {l, e, p, v};
    endfunction

    task automatic drive0(input logic p);
        pulse0 = p;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic p);
        pulse1 = p;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        reset_n  = 1'b0;
        reset1_n = 1'b0;
        pulse0   = 1'b0;
        pulse1   = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0));
        #12;
        e = exp_q.pop_front();
        checks++;
        if (obs0 !== e) $display("FAIL reset dut: got %h expected %h", obs0, e);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if (obs1 !== e) $display("FAIL reset dut1: got %h expected %h", obs1, e);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pulses at edges 0,3,6,9,12: lock after the fourth good period
    task automatic test_lock();
        obs_t e, got;
        logic p;
        for (int i = 0; i <= 12; i++) begin
            p = (i % 3 == 0);
            exp_q.push_back(mk(i == 12, 0, (i >= 3) ? 8'd3 : 8'd0, p && (i > 0)));
            drive0(p);
            got = obs0;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL lock edge %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         i, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
    endtask

    // Short period (2) while locked, then four good periods to relock
    task automatic test_short();
        obs_t e, got;
        logic p;
        for (int j = 1; j <= 14; j++) begin
            p = (j % 3 == 2);
            exp_q.push_back(mk((j == 1) || (j >= 14), j == 2,
                               (j == 1) ? 8'd3 : ((j < 5) ? 8'd2 : 8'd3), p));
            drive0(p);
            got = obs0;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL short rel %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         j, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
    endtask

    // Expected pulse omitted: err, drop to IDLE, restart cleanly
    task automatic test_omit();
        obs_t e, got;
        logic p;
        for (int r = 1; r <= 8; r++) begin
            p = (r == 5) || (r == 8);
            exp_q.push_back(mk(r <= 2, r == 3, 8'd3, r == 8));
            drive0(p);
            got = obs0;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL omit rel %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         r, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
    endtask

    // Relock, then assert reset between edges and expect immediate clear
    task automatic test_async_reset();
        obs_t e, got;
        logic p;
        for (int k = 0; k <= 8; k++) begin
            p = (k % 3 == 2);
            exp_q.push_back(mk(k == 8, 0, 8'd3, p));
            drive0(p);
            got = obs0;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL relock k %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         k, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
        pulse0 = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        got = obs0;
        e = exp_q.pop_front();
        checks++;
        if (got !== e) $display("FAIL async_reset: got %h expected %h", got, e);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // pulse_in stuck high with DIV=3: every later edge is a short period
    task automatic test_back_to_back();
        obs_t e, got;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(0, i > 0, (i > 0) ? 8'd1 : 8'd0, i > 0));
            drive0(1'b1);
            got = obs0;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL b2b edge %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         i, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
        pulse0 = 1'b0;
    endtask

    // DIV=1, LOCK_CNT=2: continuous strobe locks; a missing strobe is overdue
    task automatic test_div1();
        obs_t e, got;
        logic p;
        @(negedge clk);
        reset1_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p = (i < 6);
            if (i < 6)
                exp_q.push_back(mk(i >= 2, 0, (i > 0) ? 8'd1 : 8'd0, i > 0));
            else
                exp_q.push_back(mk(0, i == 6, 8'd1, 0));
            drive1(p);
            got = obs1;
            e = exp_q.pop_front();
            checks++;
            if (got !== e)
                $display("FAIL div1 edge %0d: got L%0b E%0b P%0d V%0b expected L%0b E%0b P%0d V%0b",
                         i, got.locked, got.err, got.period, got.pv, e.locked, e.err, e.period, e.pv);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_short();
        test_omit();
        test_async_reset();
        test_back_to_back();
        test_div1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
